lcb_reply_sched: RTL and testbench

- Request/reply sequencer for the LCB simulator's half-duplex RS485 link.
- Parses request frames from the UART receiver's byte stream and schedules the turnaround delay.
- Drives the RS485 direction pins with break-before-make.
- Streams a reply (cycle echo, answer-ROM bytes, checksum) to the UART transmitter over a start/busy handshake.
- Sits between UART RX, the answer ROM and UART TX, replacing their direct wiring.

---
 rtl/lcb_reply_sched.sv | 252 +++++++++++++++++++++++++
 tb/tb_lcb_reply_sched.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcb_reply_sched.sv
// rtl/lcb_reply_sched.sv - request parser, turnaround scheduler and reply streamer for a half-duplex RS485 link
//
// Parses SYNC / MY_ADDR / CYC request frames from the UART receiver, waits the
// bus turnaround time, switches the RS485 driver on with break-before-make,
// then streams cycle byte, REPLY_LEN answer-ROM bytes and an 8-bit checksum to
// the UART transmitter before handing the bus back to the receiver.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   iValid     one-cycle strobe, received byte on iData
//   iData      received byte
//   rom_addr   answer ROM address
//   rom_data   answer ROM data, valid one clk after rom_addr changes
//   tx_start   one-cycle pulse, loads tx_data into the transmitter
//   tx_data    byte to transmit, held until tx_busy falls
//   tx_busy    transmitter busy
//   dirTX      RS485 driver enable
//   dirRX      RS485 receiver enable
//   busy       high while a reply is scheduled or in progress
//   frame_err  one-cycle pulse on header error or inter-byte gap timeout
//   cycle_no   cycle byte of the last accepted request

module lcb_reply_sched #(
  parameter logic [7:0] SYNC      = 8'hA5,
  parameter logic [7:0] MY_ADDR   = 8'h03,
  parameter int         REPLY_LEN = 8,
  parameter int         TURN_CYC  = 400,
  parameter int         GUARD_CYC = 80,
  parameter int         GAP_CYC   = 2000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iValid,
  input  logic [7:0] iData,
  output logic [4:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic       dirTX,
  output logic       dirRX,
  output logic       busy,
  output logic       frame_err,
  output logic [7:0] cycle_no
);

  localparam int MAX_A   = (TURN_CYC > GAP_CYC) ? TURN_CYC : GAP_CYC;
  localparam int CNT_MAX = (MAX_A > GUARD_CYC) ? MAX_A : GUARD_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // Index of the checksum byte, i.e. the last byte of a reply.
  localparam logic [5:0] LAST_IDX = 6'(REPLY_LEN + 1);
  localparam logic [5:0] ROM_LEN  = 6'(REPLY_LEN);

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR,
    S_ADR,
    S_TURN,
    S_BBM_ON,
    S_GUARD_ON,
    S_SEND,
    S_WAIT_HI,
    S_WAIT_LO,
    S_GUARD_OFF,
    S_BBM_OFF
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [5:0]       idx_q;
  logic [7:0]       sum_q;
  logic [4:0]       rom_addr_q;
  logic             tx_start_q;
  logic [7:0]       tx_data_q;
  logic             dir_tx_q;
  logic             dir_rx_q;
  logic             frame_err_q;
  logic [7:0]       cycle_no_q;

  logic             gap_expired;
  logic             rom_step;
  logic             rom_byte;
  logic [7:0]       next_byte;

  // Gap counter holds clocks since the last accepted header byte.
  assign gap_expired = (cnt_q == CNT_W'(GAP_CYC - 1));

  // While byte idx is on the wire, move the ROM address to the next byte's
  // slot so rom_data has settled by the following SEND. Stops at REPLY_LEN-1.
  assign rom_step = (idx_q != 6'd0) && (idx_q < ROM_LEN);

  // Bytes 1..REPLY_LEN come from the ROM; the checksum is seeded with byte 0.
  assign rom_byte = (idx_q != 6'd0) && (idx_q <= ROM_LEN);

  always_comb begin
    next_byte = sum_q;
    if (idx_q == 6'd0) begin
      next_byte = cycle_no_q;
    end else if (idx_q <= ROM_LEN) begin
      next_byte = rom_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      sum_q       <= '0;
      rom_addr_q  <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      dir_tx_q    <= 1'b0;
      dir_rx_q    <= 1'b1;
      frame_err_q <= 1'b0;
      cycle_no_q  <= '0;
    end else begin
      tx_start_q  <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (iValid && (iData == SYNC)) begin
            state_q <= S_HDR;
            cnt_q   <= '0;
          end
        end
        S_HDR: begin
          // A received byte beats a gap expiry in the same cycle.
          if (iValid) begin
            cnt_q <= '0;
            if (iData == MY_ADDR) begin
              state_q <= S_ADR;
            end else if (iData != SYNC) begin
              state_q     <= S_IDLE;
              frame_err_q <= 1'b1;
            end
          end else if (gap_expired) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            frame_err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_ADR: begin
          if (iValid) begin
            cycle_no_q <= iData;
            cnt_q      <= CNT_W'(TURN_CYC);
            state_q    <= S_TURN;
          end else if (gap_expired) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            frame_err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_TURN: begin
          if (cnt_q <= CNT_W'(1)) begin
            dir_rx_q <= 1'b0;
            state_q  <= S_BBM_ON;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_BBM_ON: begin
          // One clock with both pins low has just elapsed. SEND itself takes
          // one clock, so the guard counter runs one short.
          dir_tx_q <= 1'b1;
          cnt_q    <= CNT_W'(GUARD_CYC - 1);
          state_q  <= S_GUARD_ON;
        end
        S_GUARD_ON: begin
          if (cnt_q <= CNT_W'(1)) begin
            rom_addr_q <= '0;
            sum_q      <= cycle_no_q;
            idx_q      <= '0;
            cnt_q      <= '0;
            state_q    <= S_SEND;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_SEND: begin
          if (!tx_busy) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= next_byte;
            cnt_q      <= '0;
            state_q    <= S_WAIT_HI;
          end
        end
        S_WAIT_HI: begin
          // A transmitter that never raises busy is treated as having taken
          // the byte after four clocks.
          if (tx_busy || (cnt_q == CNT_W'(3))) begin
            state_q <= S_WAIT_LO;
            if (rom_step) begin
              rom_addr_q <= rom_addr_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_WAIT_LO: begin
          if (!tx_busy) begin
            if (rom_byte) begin
              sum_q <= sum_q + tx_data_q;
            end
            idx_q <= idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
              cnt_q   <= CNT_W'(GUARD_CYC);
              state_q <= S_GUARD_OFF;
            end else begin
              state_q <= S_SEND;
            end
          end
        end
        S_GUARD_OFF: begin
          if (cnt_q <= CNT_W'(1)) begin
            dir_tx_q <= 1'b0;
            state_q  <= S_BBM_OFF;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_BBM_OFF: begin
          dir_rx_q <= 1'b1;
          cnt_q    <= '0;
          state_q  <= S_IDLE;
        end
        default: begin
          state_q  <= S_IDLE;
          cnt_q    <= '0;
          dir_tx_q <= 1'b0;
          dir_rx_q <= 1'b1;
        end
      endcase
    end
  end

  assign rom_addr  = rom_addr_q;
  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign dirTX     = dir_tx_q;
  assign dirRX     = dir_rx_q;
  assign frame_err = frame_err_q;
  assign cycle_no  = cycle_no_q;
  assign busy      = (state_q != S_IDLE) && (state_q != S_HDR) && (state_q != S_ADR);

endmodule

// File: tb/tb_lcb_reply_sched.sv
// tb/tb_lcb_reply_sched.sv - scoreboard bench for lcb_reply_sched

module tb_lcb_reply_sched;

  localparam int REPLY_LEN = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       iValid;
  logic [7:0] iData;
  logic [4:0] rom_addr;
  logic [7:0] rom_data;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       dirTX;
  logic       dirRX;
  logic       busy;
  logic       frame_err;
  logic [7:0] cycle_no;

  lcb_reply_sched dut (
    .clk       (clk),
    .reset     (reset),
    .iValid    (iValid),
    .iData     (iData),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .dirTX     (dirTX),
    .dirRX     (dirRX),
    .busy      (busy),
    .frame_err (frame_err),
    .cycle_no  (cycle_no)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Edge counter: at a negedge, cyc is the index of the preceding posedge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous answer ROM.
  logic [7:0] rom [32];
  always @(posedge clk) rom_data <= rom[rom_addr];

  logic [7:0] exp_q [$];

  int iv_cyc, tx_rise_cyc, rx_rise_cyc, start0_cyc, ferr_cyc, fall_seen;
  int rx_rises = 0, starts = 0, ferr_cnt = 0, rx_low = 0;
  int both_hi = 0, bbm_bad = 0, bbm_seen = 0, zero_run = 0;
  int rst_count = 0;
  logic prev_tx = 1'b0, prev_rx = 1'b1;
  logic [7:0] last_tx;

  // Output monitor and scoreboard consumer.
  always @(negedge clk) begin
    if (!reset) begin
      zero_run = 0;
    end else begin
      if (dirTX && dirRX) both_hi++;
      if (!dirTX && !dirRX) begin
        zero_run++;
      end else if (zero_run != 0) begin
        bbm_seen++;
        if (zero_run != 1) bbm_bad++;
        zero_run = 0;
      end
      if (dirTX && !prev_tx) begin
        tx_rise_cyc = cyc;
        if (prev_rx) bbm_bad++;
      end
      if (dirRX && !prev_rx) begin
        rx_rises++;
        rx_rise_cyc = cyc;
        if (prev_tx) bbm_bad++;
      end
      if (!dirRX) rx_low++;
      if (frame_err) begin
        ferr_cnt++;
        ferr_cyc = cyc;
      end
      if (tx_start) begin
        if (starts == 0) start0_cyc = cyc;
        starts++;
        chk("tx_dirTX", dirTX, 1);
        if (exp_q.size() == 0) chk("tx_extra", tx_data, 32'hFFFF_FFFF);
        else chk("tx_data", tx_data, exp_q.pop_front());
        last_tx = tx_data;
      end
    end
    prev_tx = dirTX;
    prev_rx = dirRX;
  end

  // Transmitter model: busy one clock after tx_start, held five clocks.
  logic [7:0] cap_data;
  int         cap_rc;
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (reset && tx_start) begin
        cap_data = tx_data;
        cap_rc   = rst_count;
        @(posedge clk); #1;
        tx_busy = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        if (cap_rc == rst_count) chk("tx_hold", tx_data, cap_data);
        tx_busy   = 1'b0;
        fall_seen = cyc + 1;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    iValid = 1'b1;
    iData  = b;
    @(posedge clk); #1;
    iValid = 1'b0;
    iv_cyc = cyc;
  endtask

  task automatic push_reply(input logic [7:0] c);
    logic [7:0] s;
    s = c;
    exp_q.push_back(c);
    for (int i = 0; i < REPLY_LEN; i++) begin
      exp_q.push_back(rom[i]);
      s = s + rom[i];
    end
    exp_q.push_back(s);
  endtask

  task automatic wait_reply(input string tag);
    int r0;
    r0 = rx_rises;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      if (rx_rises != r0) break;
    end
    chk({tag, "_done"}, rx_rises - r0, 1);
    chk({tag, "_drained"}, exp_q.size(), 0);
    chk({tag, "_starts"}, starts, REPLY_LEN + 2);
  endtask

  task automatic wait_starts(input int n);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      if (starts >= n && tx_busy) break;
    end
  endtask

  int t_iv, f0, g0;

  initial begin
    reset  = 1'b0;
    iValid = 1'b0;
    iData  = 8'h00;
    for (int i = 0; i < 32; i++) rom[i] = 8'(i + 1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dirRX", dirRX, 1);
    chk("rst_dirTX", dirTX, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_cycle_no", cycle_no, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);

    // 1: nominal request
    starts = 0;
    push_reply(8'h07);
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h07);
    t_iv = iv_cyc;
    wait_reply("t1");
    chk("t1_turn", tx_rise_cyc - t_iv, 401);
    chk("t1_guard_on", start0_cyc - tx_rise_cyc, 80);
    chk("t1_guard_off", rx_rise_cyc - fall_seen, 81);
    chk("t1_sum", last_tx, 8'h2B);
    chk("t1_cycle_no", cycle_no, 8'h07);

    // 2: wrong address
    starts = 0; rx_low = 0; f0 = ferr_cnt;
    send_byte(8'hA5);
    send_byte(8'h04);
    t_iv = iv_cyc;
    send_byte(8'h07);
    repeat (600) @(posedge clk);
    #1;
    chk("t2_ferr_cnt", ferr_cnt - f0, 1);
    chk("t2_ferr_at", ferr_cyc, t_iv);
    chk("t2_starts", starts, 0);
    chk("t2_rx_low", rx_low, 0);

    // 3: gap timeout, then a stray address byte
    send_byte(8'hA5);
    g0 = iv_cyc; f0 = ferr_cnt;
    for (int i = 0; i < 2100; i++) begin
      @(negedge clk); #1;
      if (ferr_cnt != f0) break;
    end
    chk("t3_ferr_cnt", ferr_cnt - f0, 1);
    chk("t3_gap", ferr_cyc - g0, 2000);
    chk("t3_busy", busy, 0);
    send_byte(8'h03);
    repeat (600) @(posedge clk);
    #1;
    chk("t3_starts", starts, 0);
    chk("t3_rx_low", rx_low, 0);

    // 4: repeated sync, random ROM contents
    for (int i = 0; i < 32; i++) rom[i] = 8'($urandom_range(0, 255));
    starts = 0; f0 = ferr_cnt;
    push_reply(8'h10);
    send_byte(8'hA5);
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h10);
    wait_reply("t4");
    chk("t4_cycle_no", cycle_no, 8'h10);
    chk("t4_ferr", ferr_cnt - f0, 0);

    // 5: local echo during the reply
    starts = 0; f0 = ferr_cnt;
    push_reply(8'h5C);
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h5C);
    wait_starts(2);
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h07);
    wait_reply("t5");
    repeat (600) @(posedge clk);
    #1;
    chk("t5_no_rerun", starts, REPLY_LEN + 2);
    chk("t5_ferr", ferr_cnt - f0, 0);
    chk("t5_cycle_no", cycle_no, 8'h5C);

    // 6: reset in the middle of a reply
    starts = 0;
    push_reply(8'h21);
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h21);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      if (starts >= 3) break;
    end
    chk("t6_reached", starts, 3);
    rst_count++;
    reset = 1'b0;
    #1;
    chk("t6_dirTX", dirTX, 0);
    chk("t6_dirRX", dirRX, 1);
    chk("t6_tx_start", tx_start, 0);
    chk("t6_busy", busy, 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    starts = 0;
    push_reply(8'h33);
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h33);
    t_iv = iv_cyc;
    wait_reply("t6");
    chk("t6_turn", tx_rise_cyc - t_iv, 401);
    chk("t6_cycle_no", cycle_no, 8'h33);

    // Direction pin invariants over the whole run.
    chk("both_high", both_hi, 0);
    chk("bbm_bad", bbm_bad, 0);
    chk("bbm_switches", bbm_seen, 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
